// File: rtl/ticket_feeder.sv
// Bill-acceptor front end: buffers validator codes and replays them as ten/twenty strobes.
// Optional invalid-code counter: define TICKET_FEEDER_REJECT_CNT_EN.
module ticket_feeder #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             in_valid,
  input  logic [1:0]       in_value,
  output logic             in_ready,
  input  logic             ready_i,
  input  logic             bill_i,
  input  logic             dispense_i,
  input  logic             return_i,
  output logic             ten,
  output logic             twenty,
  output logic [CNT_W-1:0] tickets,
  output logic [CNT_W-1:0] refunds,
  output logic [CNT_W-1:0] rejects,
  output logic             busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]      C_ONE   = 1;
  localparam logic [AW-1:0]    P_ONE   = 1;
  localparam logic [AW:0]      C_DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] N_ONE   = 1;

  typedef enum logic [1:0] {IDLE, STROBE, SETTLE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;
  logic [AW:0]      w_cnt_nxt;
  logic             r_full;
  logic             r_mem [FIFO_DEPTH];
  logic             r_ten;
  logic             r_twenty;
  logic             r_busy;
  logic [CNT_W-1:0] r_tickets;
  logic [CNT_W-1:0] r_refunds;
  logic             w_take;
  logic             w_code_ok;
  logic             w_push;
  logic             w_pop;
  logic             w_head;

  assign w_take    = in_valid & in_ready;
  assign w_code_ok = in_value[0] ^ in_value[1];
  assign w_push    = w_take & w_code_ok;
  assign w_head    = r_mem[r_rd];
  assign w_pop     = (r_state == IDLE) & (r_cnt != '0)
                   & (ready_i | bill_i);

  // full is registered, so a pop on a full edge cannot reopen in_ready early
  assign in_ready = clear_n & ~r_full;

  always_comb begin
    w_cnt_nxt = r_cnt;
    unique case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + C_ONE;
      2'b01:   w_cnt_nxt = r_cnt - C_ONE;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_pop) w_state_nxt = STROBE;
      STROBE:  w_state_nxt = SETTLE;
      SETTLE:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= in_value[1];
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state   <= IDLE;
      r_wr      <= '0;
      r_rd      <= '0;
      r_cnt     <= '0;
      r_full    <= 1'b0;
      r_ten     <= 1'b0;
      r_twenty  <= 1'b0;
      r_busy    <= 1'b0;
      r_tickets <= '0;
      r_refunds <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_full   <= (w_cnt_nxt == C_DEPTH);
      r_ten    <= w_pop & ~w_head;
      r_twenty <= w_pop & w_head;
      r_busy   <= (w_cnt_nxt != '0) | (w_state_nxt != IDLE);
      if (w_push) r_wr <= r_wr + P_ONE;
      if (w_pop)  r_rd <= r_rd + P_ONE;
      if (dispense_i && r_tickets != '1)
        r_tickets <= r_tickets + N_ONE;
      if (return_i && r_refunds != '1)
        r_refunds <= r_refunds + N_ONE;
    end
  end

`ifdef TICKET_FEEDER_REJECT_CNT_EN
  logic [CNT_W-1:0] r_rejects;
  logic             w_rej;

  assign w_rej = w_take & ~w_code_ok;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_rejects <= '0;
    end else if (w_rej && r_rejects != '1) begin
      r_rejects <= r_rejects + N_ONE;
    end
  end

  assign rejects = r_rejects;
`else
  assign rejects = '0;
`endif

  assign ten     = r_ten;
  assign twenty  = r_twenty;
  assign busy    = r_busy;
  assign tickets = r_tickets;
  assign refunds = r_refunds;

endmodule

// File: tb/tb_ticket_feeder.sv
// Bench for ticket_feeder: directed scenarios plus random traffic
// checked every cycle against a queue-based reference model.
module tb_ticket_feeder;

  localparam int DEPTH = 4;
  localparam int MAXC  = 255;
  localparam int MAXC2 = 3;

  logic       clk = 1'b0;
  logic       clear_n;
  logic       in_valid;
  logic [1:0] in_value;
  logic       in_ready;
  logic       ready_i;
  logic       bill_i;
  logic       dispense_i;
  logic       return_i;
  logic       ten;
  logic       twenty;
  logic [7:0] tickets;
  logic [7:0] refunds;
  logic [7:0] rejects;
  logic       busy;

  logic       disp2;
  logic       rdy2;
  logic       ten2;
  logic       tw2;
  logic [1:0] tk2;
  logic [1:0] rf2;
  logic [1:0] rj2;
  logic       busy2;

  int errors = 0;
  int checks = 0;

  bit q[$];
  int cool;
  int m_t, m_r, m_j, m_t2;
  int e_ten, e_tw;

  always #5 clk = ~clk;

  ticket_feeder #(.FIFO_DEPTH(DEPTH), .CNT_W(8)) u_dut (
    .clk(clk), .clear_n(clear_n),
    .in_valid(in_valid), .in_value(in_value), .in_ready(in_ready),
    .ready_i(ready_i), .bill_i(bill_i),
    .dispense_i(dispense_i), .return_i(return_i),
    .ten(ten), .twenty(twenty),
    .tickets(tickets), .refunds(refunds), .rejects(rejects),
    .busy(busy)
  );

  ticket_feeder #(.FIFO_DEPTH(DEPTH), .CNT_W(2)) u_dut2 (
    .clk(clk), .clear_n(clear_n),
    .in_valid(1'b0), .in_value(2'b00), .in_ready(rdy2),
    .ready_i(1'b0), .bill_i(1'b0),
    .dispense_i(disp2), .return_i(1'b0),
    .ten(ten2), .twenty(tw2),
    .tickets(tk2), .refunds(rf2), .rejects(rj2),
    .busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    cool = 0;
    m_t = 0; m_r = 0; m_j = 0; m_t2 = 0;
    e_ten = 0; e_tw = 0;
  endtask

  task automatic check_all();
    chk("ten", {31'b0, ten}, e_ten);
    chk("twenty", {31'b0, twenty}, e_tw);
    chk("in_ready", {31'b0, in_ready}, (q.size() != DEPTH) ? 1 : 0);
    chk("busy", {31'b0, busy}, (q.size() != 0 || cool != 0) ? 1 : 0);
    chk("tickets", {24'b0, tickets}, m_t);
    chk("refunds", {24'b0, refunds}, m_r);
`ifdef TICKET_FEEDER_REJECT_CNT_EN
    chk("rejects", {24'b0, rejects}, m_j);
`else
    chk("rejects", {24'b0, rejects}, 0);
`endif
    chk("tickets_w2", {30'b0, tk2}, m_t2);
  endtask

  // One clock edge: advance the model from the stable inputs, then check.
  task automatic step();
    int  qs;
    bit  acc;
    bit  pop;
    @(posedge clk);
    qs  = q.size();
    acc = in_valid && (qs != DEPTH);
    pop = (cool == 0) && (qs > 0) && (ready_i || bill_i);
    e_ten = 0;
    e_tw  = 0;
    if (pop) begin
      if (q[0]) e_tw = 1;
      else      e_ten = 1;
      void'(q.pop_front());
      cool = 2;
    end else if (cool > 0) begin
      cool--;
    end
    if (acc && (in_value == 2'b01 || in_value == 2'b10))
      q.push_back(in_value == 2'b10);
    if (acc && (in_value == 2'b00 || in_value == 2'b11) && m_j < MAXC)
      m_j++;
    if (dispense_i && m_t < MAXC)  m_t++;
    if (return_i && m_r < MAXC)    m_r++;
    if (disp2 && m_t2 < MAXC2)     m_t2++;
    #1;
    check_all();
  endtask

  task automatic push(input logic [1:0] code);
    in_valid = 1'b1;
    in_value = code;
    step();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_reset();
    chk("rst_ten", {31'b0, ten}, 0);
    chk("rst_twenty", {31'b0, twenty}, 0);
    chk("rst_in_ready", {31'b0, in_ready}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_tickets", {24'b0, tickets}, 0);
    chk("rst_refunds", {24'b0, refunds}, 0);
    chk("rst_rejects", {24'b0, rejects}, 0);
  endtask

  initial begin
    clear_n    = 1'b0;
    in_valid   = 1'b0;
    in_value   = 2'b00;
    ready_i    = 1'b0;
    bill_i     = 1'b0;
    dispense_i = 1'b0;
    return_i   = 1'b0;
    disp2      = 1'b0;
    model_clear();
    #22;
    check_reset();
    @(negedge clk);
    clear_n = 1'b1;
    idle(2);

    // single ten with ready high
    ready_i = 1'b1;
    push(2'b01);
    idle(5);
    ready_i = 1'b0;

    // back-to-back codes with bill held
    bill_i = 1'b1;
    push(2'b10);
    push(2'b01);
    push(2'b01);
    idle(12);
    bill_i = 1'b0;

    // fill the FIFO while the machine is busy
    in_valid = 1'b1;
    in_value = 2'b10;
    step();
    in_value = 2'b01;
    step();
    in_value = 2'b10;
    step();
    in_value = 2'b01;
    step();
    in_value = 2'b10;
    step();
    chk("full_in_ready", {31'b0, in_ready}, 0);
    in_valid = 1'b0;
    idle(3);
    ready_i = 1'b1;
    idle(15);
    ready_i = 1'b0;

    // invalid codes are consumed
    push(2'b00);
    push(2'b11);
    idle(2);

    // audit counters, including saturation of the narrow build
    for (int i = 0; i < 3; i++) begin
      dispense_i = 1'b1;
      step();
      dispense_i = 1'b0;
      step();
    end
    return_i = 1'b1;
    step();
    return_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      disp2 = 1'b1;
      step();
    end
    disp2 = 1'b0;
    step();
    chk("sat_w2", {30'b0, tk2}, 3);

    // reset in the middle of a strobe with bills queued
    push(2'b01);
    push(2'b10);
    push(2'b01);
    ready_i = 1'b1;
    step();
    #2;
    clear_n = 1'b0;
    #1;
    check_reset();
    model_clear();
    ready_i = 1'b0;
    @(negedge clk);
    clear_n = 1'b1;
    idle(4);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      in_valid   = ($urandom_range(0, 2) != 0);
      in_value   = 2'($urandom_range(0, 3));
      ready_i    = ($urandom_range(0, 3) == 0);
      bill_i     = ($urandom_range(0, 4) == 0);
      dispense_i = ($urandom_range(0, 3) == 0);
      return_i   = ($urandom_range(0, 5) == 0);
      disp2      = ($urandom_range(0, 1) == 0);
      step();
    end
    in_valid = 1'b0;
    ready_i  = 1'b1;
    idle(16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ticket_feeder.md
# ticket_feeder

Bill-acceptor front end that drives the ticket machine's `ten`/`twenty` inputs. It accepts validated bill codes from the bill validator over a valid/ready handshake and buffers them in a small FIFO. It replays each bill as a one-cycle strobe only when the machine reports `ready` or `bill`. It also counts the machine's `dispense` and `return_sig` outputs for the service/audit logic.

## Interface
- `FIFO_DEPTH`, 4: bill buffer entries; power of two, ≥2.
- `CNT_W`, 8: width of ticket/refund/reject counters.

- `clk`  in  1  rising-edge clock shared with ticket machine
- `clear_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  validator presents a bill code
- `in_value`  in  2  01 = ten, 10 = twenty, 00/11 = invalid
- `in_ready`  out  1  feeder can accept a code this cycle
- `ready_i`  in  1  machine `ready` output
- `bill_i`  in  1  machine `bill` output
- `dispense_i`  in  1  machine `dispense` output
- `return_i`  in  1  machine `return_sig` output
- `ten`  out  1  registered one-cycle strobe to machine
- `twenty`  out  1  registered one-cycle strobe to machine
- `tickets`  out  CNT_W  dispense count, saturating
- `refunds`  out  CNT_W  return count, saturating
- `rejects`  out  CNT_W  invalid-code count, saturating (see Configuration)
- `busy`  out  1  FIFO non-empty or FSM not IDLE

## Operation
- Reset (`clear_n` low, asynchronous):
  - FIFO is emptied and FSM goes to IDLE.
  - `ten`, `twenty`, `tickets`, `refunds`, `rejects` and `busy` are 0.
  - `in_ready` is forced to 0 while `clear_n` is low.
- Handshake:
  - `in_ready` = !full.
  - A transfer occurs on the rising edge where `in_valid & in_ready`.
  - Valid codes (01/10) are pushed.
  - Invalid codes (00/11) complete the handshake, are discarded and increment `rejects`.
  - `in_value` is ignored while `in_valid` is 0.
- FIFO:
  - Circular buffer with wrap-around pointers and an occupancy count of `$clog2(FIFO_DEPTH)+1` bits.
  - Push and pop in the same edge leave the count unchanged.
  - When full, a same-cycle pop does not raise `in_ready`; it uses the registered full flag.
- FSM states:
  - IDLE → STROBE when FIFO non-empty and `ready_i | bill_i`. On that edge the head is popped and `ten` (code 01) or `twenty` (code 10) is set to 1.
  - STROBE → SETTLE unconditionally. The strobe clears, giving exactly one cycle high.
  - SETTLE → IDLE unconditionally. This lets the machine's registered outputs reflect the new state before the next decision.
  - IDLE stays IDLE while FIFO is empty, or while `ready_i` and `bill_i` are both 0 (machine in DISP/RTN). The bill is held in the FIFO, never dropped.
- `ten` and `twenty` are never 1 together.
- Counters: `tickets` +1 on every edge with `dispense_i` = 1, and `refunds` +1 on every edge with `return_i` = 1. All counters saturate at 2^CNT_W−1 and never wrap.

## Timing
- Acceptance latency: a code accepted into an empty FIFO at edge e, with the machine ready, produces a strobe high from edge e+1 to e+2.
- Strobe spacing is at least 3 cycles (IDLE/STROBE/SETTLE), so peak throughput is one bill per 3 cycles.
- Counters and `busy` are registered, 1-cycle latency from the observed input.
- Reset asserted mid-strobe clears `ten`/`twenty` immediately (asynchronous); buffered bills are lost.
- `ready_i`/`bill_i` are sampled only in IDLE; changes during STROBE/SETTLE have no effect.

## Configuration
- `TICKET_FEEDER_REJECT_CNT_EN`:
  - Defined: `rejects` counter is built as described.
  - Undefined: no counter register; invalid codes are still accepted and discarded, and `rejects` is tied to 0.

## Test plan
- Reset, then push 01 with `ready_i`=1 → `ten` high exactly one cycle, starting 1 cycle after acceptance; `twenty` stays 0; `busy` returns to 0 after SETTLE.
- Push 10,01,01 back-to-back with `bill_i`=1 held → strobes `twenty`,`ten`,`ten`, each one cycle, spaced 3 cycles apart, order preserved.
- With `ready_i`=`bill_i`=0, push 5 codes at `FIFO_DEPTH`=4 → first 4 accepted, `in_ready`=0 on the 5th. Release `ready_i`=1 → 4 strobes, after which `in_ready` returns to 1.
- Push 00 then 11 → both handshakes complete, no strobe; `rejects`=2 with the macro defined, 0 without.
- Pulse `dispense_i` 3× and `return_i` 1×, plus a `CNT_W`=2 build with 5 dispenses → `tickets`=3 and `refunds`=1; the CNT_W=2 build saturates `tickets` at 3.
- Assert `clear_n`=0 during STROBE with 2 bills queued → `ten`/`twenty` drop immediately, FIFO is empty and counters are 0 after release.
